// File: rtl/wb_tester_pkg.sv
// Shared types and LFSR helpers for the Wishbone memory self-test master.
package wb_tester_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WRITE,
      ST_GAP,
      ST_READ,
      ST_DONE
   } tester_state_t;

   localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

   // Galois form, shifting left: the MSB decides whether the taps are folded in.
   function automatic logic [31:0] lfsr_next(input logic [31:0] l);
      return {l[30:0], 1'b0} ^ (l[31] ? LFSR_POLY : 32'h0);
   endfunction

endpackage

// File: rtl/wshb_if.sv
// Shared Wishbone bus bundle used by the memory slaves and by the tester master.
interface wshb_if (
   input logic clk,
   input logic rst
);
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic        ack;

   modport master (
      output cyc, stb, we, sel, adr, dat_ms,
      input  ack, dat_sm
   );

   modport slave (
      input  clk, rst, cyc, stb, we, sel, adr, dat_ms,
      output ack, dat_sm
   );
endinterface

// File: rtl/wb_lfsr32.sv
// Loadable 32-bit pattern generator; a zero seed is replaced by 1 so the sequence never locks up.
module wb_lfsr32
   import wb_tester_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        step,
   input  logic [31:0] seed,
   output logic [31:0] value
);

   always_ff @(posedge clk) begin
      if (!rst)
         value <= 32'h1;
      else if (load)
         value <= (seed == 32'h0) ? 32'h1 : seed;
      else if (step)
         value <= lfsr_next(value);
   end

endmodule

// File: rtl/wb_mem_tester.sv
// Wishbone write-then-verify memory self-test master.
// Optional watchdog on ack is enabled with the WB_TESTER_TIMEOUT_EN macro.
module wb_mem_tester
   import wb_tester_pkg::*;
#(
   parameter int          mem_adr_width = 11,
   parameter logic [31:0] BASE_ADR      = 32'h0,
   parameter int          TIMEOUT       = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] seed,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [15:0] err_count,
   output logic [31:0] first_err_adr,
   wshb_if.master      wb_m
);

   localparam logic [mem_adr_width-1:0] IDX_LAST = '1;

   tester_state_t            state, next_state;
   logic [mem_adr_width-1:0] idx;
   logic [31:0]              seed_q;
   logic                     timeout_q;
   logic [31:0]              lfsr_val;
   logic [31:0]              lfsr_seed;
   logic                     lfsr_load, lfsr_step;
   logic                     cyc, stb, we;
   logic [3:0]               sel;
   logic [31:0]              adr, dat_ms;
   logic                     last_word;
   logic                     wd_expire;

   assign last_word = (idx == IDX_LAST);

   wb_lfsr32 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .load  (lfsr_load),
      .step  (lfsr_step),
      .seed  (lfsr_seed),
      .value (lfsr_val)
   );

`ifdef WB_TESTER_TIMEOUT_EN
   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
   logic [7:0] wd_cnt;

   // Counts stalled strobe cycles of the current access; fires on the cycle the limit is hit.
   assign wd_expire = stb && !wb_m.ack && ((wd_cnt + 8'd1) == TIMEOUT_CNT);

   always_ff @(posedge clk) begin
      if (!rst || !stb || wb_m.ack)
         wd_cnt <= 8'd0;
      else
         wd_cnt <= wd_cnt + 8'd1;
   end
`else
   assign wd_expire = 1'b0;
`endif

   always_comb begin
      next_state = state;
      cyc        = 1'b0;
      stb        = 1'b0;
      we         = 1'b0;
      sel        = 4'h0;
      adr        = 32'h0;
      dat_ms     = 32'h0;
      lfsr_load  = 1'b0;
      lfsr_step  = 1'b0;
      lfsr_seed  = seed;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               next_state = ST_WRITE;
               lfsr_load  = 1'b1;
            end
         end
         ST_WRITE: begin
            cyc    = 1'b1;
            stb    = 1'b1;
            we     = 1'b1;
            sel    = 4'hF;
            adr    = BASE_ADR + (32'(idx) << 2);
            dat_ms = lfsr_val;
            if (wb_m.ack) begin
               lfsr_step = 1'b1;
               if (last_word)
                  next_state = ST_GAP;
            end
         end
         // Replaying the same seed regenerates the written pattern for comparison.
         ST_GAP: begin
            lfsr_load  = 1'b1;
            lfsr_seed  = seed_q;
            next_state = ST_READ;
         end
         ST_READ: begin
            cyc = 1'b1;
            stb = 1'b1;
            sel = 4'hF;
            adr = BASE_ADR + (32'(idx) << 2);
            if (wb_m.ack) begin
               lfsr_step = 1'b1;
               if (last_word)
                  next_state = ST_DONE;
            end
         end
         default: next_state = ST_IDLE;
      endcase
      if (wd_expire)
         next_state = ST_DONE;
   end

   // Index, seed latch and result bookkeeping; reset wins over everything so cyc drops at once.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= ST_IDLE;
         idx           <= '0;
         seed_q        <= 32'h0;
         err_count     <= 16'h0;
         first_err_adr <= 32'h0;
         timeout_q     <= 1'b0;
      end else begin
         state <= next_state;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  seed_q        <= seed;
                  idx           <= '0;
                  err_count     <= 16'h0;
                  first_err_adr <= 32'h0;
                  timeout_q     <= 1'b0;
               end
            end
            ST_WRITE: begin
               if (wb_m.ack)
                  idx <= idx + 1'b1;
            end
            ST_GAP: idx <= '0;
            ST_READ: begin
               if (wb_m.ack) begin
                  idx <= idx + 1'b1;
                  if (wb_m.dat_sm != lfsr_val) begin
                     if (err_count != 16'hFFFF)
                        err_count <= err_count + 16'h1;
                     if (err_count == 16'h0)
                        first_err_adr <= adr;
                  end
               end
            end
            default: ;
         endcase
         if (wd_expire)
            timeout_q <= 1'b1;
      end
   end

   assign busy    = (state == ST_WRITE) || (state == ST_GAP) || (state == ST_READ);
   assign done    = (state == ST_DONE);
   assign timeout = done && timeout_q;
   assign pass    = done && (err_count == 16'h0) && !timeout_q;

   assign wb_m.cyc    = cyc;
   assign wb_m.stb    = stb;
   assign wb_m.we     = we;
   assign wb_m.sel    = sel;
   assign wb_m.adr    = adr;
   assign wb_m.dat_ms = dat_ms;

endmodule
